// File: rtl/rll_pkg.sv
// Shared definitions for the keyed pipeline: FSM state encoding and the
// width helper used to size the key bit counter.
package rll_pkg;

   // Key-management states. NOKEY after reset, LOAD while shifting a key in,
   // ARMED once a complete key is active and data may flow.
   typedef enum logic [1:0] {
      NOKEY = 2'd0,
      LOAD  = 2'd1,
      ARMED = 2'd2
   } rll_state_e;

   // Ceiling log2, minimum 1 bit. The key counter must reach KEY_BITS,
   // so callers size it as clog2(KEY_BITS+1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rll_pipe_stage.sv
// One valid/ready register slice. Holds a single word; accepts a new word
// whenever it is empty or its current word leaves in the same cycle.
//
// Handshake: a word transfers on a clock edge where valid and ready are both
// high. valid, once raised, stays high with data unchanged until the transfer;
// ready may depend combinationally on the downstream ready but never on valid.
module rll_pipe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             valid_q;
   logic             valid_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   assign in_ready  = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   // Next-state: load on acceptance, otherwise hold (data stays put under backpressure).
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
         end
      end
   end

   // Slice register with synchronous reset to empty / zero data.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/rll_keyed_pipe.sv
// Keyed data pipeline. A key is shifted in serially (LSB first) into a shadow
// register and becomes active only once complete. Data words are XOR-masked
// with the active key (repeated across the word, polarity-adjusted by KEY_POL)
// as they enter stage 1, then pass through two valid/ready register slices.
// A wrong key scrambles the data; the correct key (active == KEY_POL) passes
// it unchanged. Words already in flight keep the mask they were captured with.
//
// Handshake: on both the upstream (in_*) and downstream (out_*) sides a word
// moves on a clock edge where valid and ready are both high; valid holds with
// stable data until accepted, and ready never depends on valid. Key bits move
// on key_valid & key_ready in the same way.
module rll_keyed_pipe
   import rll_pkg::*;
#(
   parameter int                  WIDTH    = 32,
   parameter int                  KEY_BITS = 32,
   parameter logic [KEY_BITS-1:0] KEY_POL  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_start,
   input  logic             key_valid,
   input  logic             key_bit,
   output logic             key_ready,
   output logic             key_done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = clog2(KEY_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_BITS - 1);

   rll_state_e          state_q;
   rll_state_e          state_d;
   logic [KEY_BITS-1:0] shadow_q;
   logic [KEY_BITS-1:0] shadow_d;
   logic [KEY_BITS-1:0] active_q;
   logic [KEY_BITS-1:0] active_d;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;
   logic                key_done_q;
   logic                key_done_d;

   logic [WIDTH-1:0]    mask;
   logic                armed;
   logic                s1_in_valid;
   logic                s1_in_ready;
   logic                s1_out_valid;
   logic [WIDTH-1:0]    s1_out_data;
   logic                s2_in_ready;

   assign armed     = (state_q == ARMED);
   assign key_ready = (state_q == LOAD);
   assign key_done  = key_done_q;
   assign dbg_state = state_q;

   // Key loader next-state: key_start wins over a simultaneous key bit; the
   // final bit promotes the shadow to active and announces it via key_done.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      count_d    = count_q;
      key_done_d = 1'b0;
      if (key_start) begin
         state_d  = LOAD;
         shadow_d = '0;
         count_d  = '0;
      end else if (key_ready && key_valid) begin
         for (int i = 0; i < KEY_BITS; i++) begin
            if (count_q == CNT_W'(i)) begin
               shadow_d[i] = key_bit;
            end
         end
         count_d = count_q + CNT_W'(1);
         if (count_q == LAST_IDX) begin
            active_d   = shadow_d;
            key_done_d = 1'b1;
            state_d    = ARMED;
         end
      end
   end

   // Key loader registers; reset drops any partial or active key.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= NOKEY;
         shadow_q   <= '0;
         active_q   <= '0;
         count_q    <= '0;
         key_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         count_q    <= count_d;
         key_done_q <= key_done_d;
      end
   end

   // Mask: active key tiled across the word, bit-wise inverted where KEY_POL is 1.
   always_comb begin
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         mask[i] = active_q[i % KEY_BITS] ^ KEY_POL[i % KEY_BITS];
      end
   end

   // Data is only admitted while a complete key is active.
   assign s1_in_valid = in_valid && armed;
   assign in_ready    = armed && s1_in_ready;

   rll_pipe_stage #(.WIDTH(WIDTH)) u_stage1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_in_valid),
      .in_ready  (s1_in_ready),
      .in_data   (in_data ^ mask),
      .out_valid (s1_out_valid),
      .out_ready (s2_in_ready),
      .out_data  (s1_out_data)
   );

   rll_pipe_stage #(.WIDTH(WIDTH)) u_stage2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_out_valid),
      .in_ready  (s2_in_ready),
      .in_data   (s1_out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

endmodule
